// File: rtl/capsense_pkg.sv
// capsense_pkg: shared FSM state encoding for the capacitive touch scanner
package capsense_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/capsense_track.sv
// capsense_track: per-channel hysteresis touch filter; CAPSENSE_BASELINE_EN adds a drifting baseline
module capsense_track #(
    parameter int CNT_BITS = 8,
    parameter int THRESH   = 115,
    parameter int HYST     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                update,
    input  logic [CNT_BITS-1:0] count,
    output logic                touched
);

    localparam logic [CNT_BITS-1:0] ON  = CNT_BITS'(THRESH);
    localparam logic [CNT_BITS-1:0] OFF = CNT_BITS'(THRESH - HYST);

    logic flag;
    logic nxt;

`ifdef CAPSENSE_BASELINE_EN
    logic [CNT_BITS-1:0] base;
    logic [CNT_BITS-1:0] m;
    logic                valid;

    // Metric is the saturating delta over baseline; first report only seeds the baseline
    always_comb begin
        m   = count > base ? count - base : '0;
        nxt = !valid ? 1'b0 : flag ? !(m < OFF) : m > ON;
    end

    // Baseline creeps one step toward the count while untouched, frozen while touched
    always_ff @(posedge clk) begin
        if (reset) begin
            flag  <= 1'b0;
            valid <= 1'b0;
            base  <= '0;
        end else if (update) begin
            flag  <= nxt;
            valid <= 1'b1;
            base  <= !valid ? count :
                     nxt ? base :
                     count > base ? base + CNT_BITS'(1) :
                     count < base ? base - CNT_BITS'(1) : base;
        end
    end
`else
    assign nxt = flag ? !(count < OFF) : count > ON;

    // Touch flag latches the hysteresis decision on each report of this channel
    always_ff @(posedge clk) begin
        if (reset) flag <= 1'b0;
        else if (update) flag <= nxt;
    end
`endif

    // The new decision is already visible during the report cycle itself
    assign touched = update ? nxt : flag;

endmodule

// File: rtl/capsense_scan.sv
// capsense_scan: multi-channel capacitive touch scanner (optional CAPSENSE_BASELINE_EN baseline tracking)
module capsense_scan
    import capsense_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int CNT_BITS     = 8,
    parameter int DRIVE_CYCLES = 3,
    parameter int TIMEOUT      = 255,
    parameter int THRESH       = 115,
    parameter int HYST         = 8,
    localparam int CH_W        = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CHANNELS-1:0] sense,
    output logic [CHANNELS-1:0] drive_oe,
    output logic                busy,
    output logic [CNT_BITS-1:0] count,
    output logic [CH_W-1:0]     count_ch,
    output logic                count_valid,
    output logic [CHANNELS-1:0] touched
);

    localparam int DW = $clog2(DRIVE_CYCLES + 1);

    state_t                state, state_n;
    logic [CHANNELS-1:0]   s1, s2;
    logic [CH_W-1:0]       ch;
    logic [DW-1:0]         dcnt;
    logic [CNT_BITS-1:0]   timer;
    logic                  sense_ch;
    logic                  drive_done;
    logic                  sample_done;
    logic                  last;

    assign sense_ch    = s2[ch];
    assign drive_done  = dcnt == DW'(DRIVE_CYCLES - 1);
    assign sample_done = sense_ch || timer == CNT_BITS'(TIMEOUT);
    assign last        = ch == CH_W'(CHANNELS - 1);

    // Two-flop synchronizer on the asynchronous pad inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sense;
            s2 <= s1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else state <= state_n;
    end

    // Next-state logic: discharge, time the recharge, report, advance channel
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   state_n = start ? ST_DRIVE : ST_IDLE;
            ST_DRIVE:  state_n = drive_done ? ST_SAMPLE : ST_DRIVE;
            ST_SAMPLE: state_n = sample_done ? ST_REPORT : ST_SAMPLE;
            default:   state_n = last ? ST_IDLE : ST_DRIVE;
        endcase
    end

    // Channel index, drive counter, saturating charge timer and held report
    always_ff @(posedge clk) begin
        if (reset) begin
            ch       <= '0;
            dcnt     <= '0;
            timer    <= '0;
            count    <= '0;
            count_ch <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ch   <= '0;
                    dcnt <= '0;
                end
                ST_DRIVE: begin
                    dcnt  <= dcnt + DW'(1);
                    timer <= '0;
                end
                ST_SAMPLE: begin
                    if (!sample_done) begin
                        timer <= timer + CNT_BITS'(1);
                    end else begin
                        count    <= timer;
                        count_ch <= ch;
                    end
                end
                default: begin
                    ch   <= last ? ch : ch + CH_W'(1);
                    dcnt <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from the current state; only the active pad is ever driven
    always_comb begin
        busy        = state != ST_IDLE;
        count_valid = state == ST_REPORT;
        drive_oe    = state == ST_DRIVE ? CHANNELS'(1) << ch : '0;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_track
        capsense_track #(
            .CNT_BITS(CNT_BITS),
            .THRESH  (THRESH),
            .HYST    (HYST)
        ) u_track (
            .clk    (clk),
            .reset  (reset),
            .update (state == ST_REPORT && ch == CH_W'(i)),
            .count  (count),
            .touched(touched[i])
        );
    end

endmodule

// File: tb/tb_capsense_scan.sv
// tb_capsense_scan: scoreboard bench for capsense_scan (honours CAPSENSE_BASELINE_EN)
module tb_capsense_scan;

`ifdef CAPSENSE_BASELINE_EN
    localparam int TH = 20;
`else
    localparam int TH = 115;
`endif
    localparam int HY = 8;

    logic       clk = 0, reset = 1, start = 0;
    logic [3:0] sense, drive_oe, touched;
    logic       busy, count_valid;
    logic [7:0] count;
    logic [1:0] count_ch;

    capsense_scan #(
        .CHANNELS(4), .CNT_BITS(8), .DRIVE_CYCLES(3),
        .TIMEOUT(255), .THRESH(TH), .HYST(HY)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .sense(sense),
        .drive_oe(drive_oe), .busy(busy), .count(count),
        .count_ch(count_ch), .count_valid(count_valid), .touched(touched)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; int cnt; int t;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, errors = 0, nvalid = 0, exp_len = 0;
    int rel[4] = '{default: 1000000};
    int tgt[4] = '{default: 0};
    int mt[4]  = '{default: 0};
    int bs[4]  = '{default: 0};
    int bv[4]  = '{default: 0};

    // Pad model: charge time measured from release; sense rises once rel reaches tgt
    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            rel[i] <= drive_oe[i] ? 0 : (rel[i] < 1000000 ? rel[i] + 1 : rel[i]);

    always_comb
        for (int i = 0; i < 4; i++) sense[i] = rel[i] >= tgt[i];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int i, input int c);
        int n;
`ifdef CAPSENSE_BASELINE_EN
        if (bv[i] == 0) begin
            bv[i] = 1;
            bs[i] = c;
            n = 0;
        end else begin
            int m;
            m = c > bs[i] ? c - bs[i] : 0;
            n = mt[i] != 0 ? int'(m >= TH - HY) : int'(m > TH);
            if (n == 0 && c != bs[i]) bs[i] += c > bs[i] ? 1 : -1;
        end
`else
        n = mt[i] != 0 ? int'(c >= TH - HY) : int'(c > TH);
`endif
        mt[i] = n;
        return n;
    endfunction

    function automatic int touch_vec();
        int v = 0;
        for (int i = 0; i < 4; i++) v |= mt[i] << i;
        return v;
    endfunction

    // Configure pad charge counts (255 = pad never rises) and queue the expected reports
    task automatic prep(input int c0, input int c1, input int c2, input int c3);
        int c[4];
        exp_t x;
        c = '{c0, c1, c2, c3};
        exp_len = 0;
        for (int i = 0; i < 4; i++) begin
            tgt[i] = c[i] >= 255 ? (1 << 30) : c[i] - 2;
            x.ch  = i;
            x.cnt = c[i] > 255 ? 255 : c[i];
            x.t   = model(i, x.cnt);
            q.push_back(x);
            exp_len += 3 + x.cnt + 2;
        end
    endtask

    task automatic scan(input bit poke, input bit b2b, input int left);
        int n = 0;
        if (!b2b) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        check("busy_rise", busy, 1);
        check("drive0", drive_oe, 1);
        while (busy && n < 5000) begin
            n++;
            start = poke && n == 20;
            @(negedge clk);
        end
        start = 0;
        check("busy_len", n, exp_len);
        check("q_left", q.size(), left);
        check("touched_vec", touched, touch_vec());
    endtask

    // Scoreboard: each report strobe pops one expected entry
    always @(negedge clk) begin
        if (count_valid) begin
            nvalid++;
            if (q.size() == 0) begin
                check("extra_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("count", count, e.cnt);
                check("count_ch", count_ch, e.ch);
                check("touch", touched[count_ch], e.t);
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_drive", drive_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_count_ch", count_ch, 0);
        check("rst_valid", count_valid, 0);
        check("rst_touched", touched, 0);
        reset = 0;

        prep(10, 10, 10, 10);   scan(0, 0, 0);
        prep(10, 10, 120, 10);  scan(0, 0, 0);
        prep(10, 10, 110, 10);  scan(0, 0, 0);
        prep(10, 10, 106, 10);  scan(0, 0, 0);
        prep(10, 255, 10, 10);  scan(0, 0, 0);

        prep(200, 50, 10, 10);
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        n = 0;
        while (!drive_oe[1] && n < 500) begin n++; @(negedge clk); end
        while (drive_oe[1] && n < 500) begin n++; @(negedge clk); end
        check("mid_reach", int'(n < 500), 1);
        repeat (5) @(negedge clk);
        reset = 1;
        q.delete();
        for (int i = 0; i < 4; i++) begin mt[i] = 0; bs[i] = 0; bv[i] = 0; end
        @(negedge clk);
        check("mid_drive", drive_oe, 0);
        check("mid_busy", busy, 0);
        check("mid_touched", touched, 0);
        check("mid_valid", count_valid, 0);
        check("mid_count", count, 0);
        reset = 0;
        nvalid = 0;
        repeat (40) @(negedge clk);
        check("mid_no_valid", nvalid, 0);

`ifdef CAPSENSE_BASELINE_EN
        prep(50, 50, 50, 50);   scan(0, 0, 0);
        prep(75, 50, 50, 53);   scan(0, 0, 0);
        prep(62, 50, 50, 71);   scan(0, 0, 0);
`endif

        prep(10, 10, 10, 10);
        prep(10, 10, 10, 10);
        scan(1, 0, 4);
        scan(0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
